pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Next-PC controller for the 8-bit processor. It drives the input of the PC register and closes the loop from that register's output. It chooses among sequential fetch, jump, taken branch, hazard stall and halt. On a redirect it generates the IF/ID flush, and it holds the PC through a configurable refill window. It also exports fetch-valid and state for the pipeline and debug logic.

Parameters:
PC_W, 8, width of PC and targets
RESET_VEC, 8'h00, PC value driven during INIT
FLUSH_CYCLES, 2, cycles flush is high per redirect, including the redirect cycle; legal range 1..4

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
pcCur  in  PC_W  current PC (PC register output)
stall  in  1  hazard-unit stall request
branchTaken  in  1  conditional branch resolved taken
branchTarget  in  PC_W  branch destination
jump  in  1  unconditional jump
jumpTarget  in  PC_W  jump destination
halt  in  1  halt instruction decoded
resume  in  1  leave HALT
pcNext  out  PC_W  value for PC register input (combinational from state/inputs)
flush  out  1  squash IF/ID contents
fetchValid  out  1  instruction fetched this cycle is on the correct path
state  out  2  INIT=0, RUN=1, FLUSH=2, HALT=3
redirectCount  out  8  accepted redirects, saturating

Behaviour:
- Single clock. Reset is synchronous, active-high, sampled on the rising edge of clk, and overrides every input in every state.
- Reset values: state=INIT, flush counter=0, redirectCount=0. While in INIT, pcNext=RESET_VEC, flush=1, fetchValid=0.
- INIT: lasts exactly one cycle after rst is sampled low, then moves to RUN. All other inputs are ignored.
- RUN: inputs are evaluated by priority jump > branchTaken > halt > stall > sequential.
  - jump: pcNext=jumpTarget; flush=1; fetchValid=0; redirectCount+1.
  - branchTaken: pcNext=branchTarget; flush=1; fetchValid=0; redirectCount+1.
  - After a redirect with FLUSH_CYCLES=1, the state stays RUN. Otherwise it goes to FLUSH, and the counter loads FLUSH_CYCLES-1.
  - halt: pcNext=pcCur; flush=0; fetchValid=0; next state HALT.
  - stall: pcNext=pcCur; flush=0; fetchValid=0; state stays RUN.
  - sequential: pcNext=pcCur+1, modulo 2^PC_W (8'hFF wraps to 8'h00, no flag); flush=0; fetchValid=1.
- FLUSH:
  - Outputs: pcNext=pcCur (hold); flush=1; fetchValid=0.
  - The counter decrements each cycle. When the counter is 1 at a clock edge, the next state is RUN.
  - jump, branchTaken, halt and stall are ignored, because they come from squashed instructions.
- HALT:
  - Outputs: pcNext=pcCur; flush=0; fetchValid=0.
  - jump, branchTaken and stall are ignored.
  - resume=1 moves to RUN on the next cycle; the PC is still held during the resume cycle.
- redirectCount saturates at 8'hFF. Only redirects accepted in RUN increment it.
- Simultaneous jump and branchTaken: jump wins. The count increments by 1 only.
- Redirect with stall in the same cycle: the redirect wins, and the stall is dropped.
- Reset mid-FLUSH or mid-HALT: the next cycle is INIT, the counter is cleared and redirectCount=0.
- The only combinational paths from inputs to pcNext and flush are in RUN. All state, counter and redirectCount updates are registered.

Test Plan:
- rst=1 for 2 cycles, then 0, with a PC register model closing the loop -> INIT for 1 cycle (pcNext=00, flush=1, fetchValid=0). Then pcNext 01,02,03 and fetchValid=1.
- Force pcCur=8'hFF in RUN with no events -> pcNext=8'h00, fetchValid=1, no other change.
- pcCur=10, jump=1 with jumpTarget=40 and branchTaken=1 with branchTarget=20 in the same cycle -> pcNext=40, flush=1, redirectCount=1. Next cycle: FLUSH with pcNext=40, flush=1, fetchValid=0. Then RUN with pcNext=41.
- stall=1 for 3 cycles at pcCur=05 -> pcNext=05, flush=0, fetchValid=0 each cycle. branchTaken with target 60 during a stall -> pcNext=60, flush=1.
- halt at pcCur=30 -> HALT, pcNext=30 held for 10 cycles. jump with target 50 in HALT is ignored. resume -> RUN next cycle, then pcNext=31.
- 256 back-to-back redirects with FLUSH_CYCLES=1 -> redirectCount stops at FF. rst asserted during a FLUSH of a later run -> state=INIT, redirectCount=00, pcNext=00 next cycle.

Source files
------------

// File: rtl/pc_sequencer.sv
// Next-PC controller: selects sequential, jump, branch, stall or halt PC,
// generates the IF/ID flush window on redirects and counts accepted redirects.
module pc_sequencer #(
  parameter int              PC_W         = 8,
  parameter logic [PC_W-1:0] RESET_VEC    = '0,
  parameter int              FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] pcCur,
  input  logic            stall,
  input  logic            branchTaken,
  input  logic [PC_W-1:0] branchTarget,
  input  logic            jump,
  input  logic [PC_W-1:0] jumpTarget,
  input  logic            halt,
  input  logic            resume,
  output logic [PC_W-1:0] pcNext,
  output logic            flush,
  output logic            fetchValid,
  output logic [1:0]      state,
  output logic [7:0]      redirectCount
);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t     state_q;
  logic [2:0] cnt_q;
  logic [7:0] rc_q;
  logic       redirect;

  // Handshake note: there is no valid/ready pair here; every input is a
  // level that is sampled each cycle and only acted on in RUN (resume in HALT).
  assign redirect      = (state_q == S_RUN) && (jump || branchTaken);
  assign state         = state_q;
  assign redirectCount = rc_q;

  always_comb begin
    pcNext     = pcCur;
    flush      = 1'b0;
    fetchValid = 1'b0;
    case (state_q)
      S_INIT: begin
        pcNext = RESET_VEC;
        flush  = 1'b1;
      end
      S_RUN: begin
        if (jump) begin
          pcNext = jumpTarget;
          flush  = 1'b1;
        end else if (branchTaken) begin
          pcNext = branchTarget;
          flush  = 1'b1;
        end else if (halt || stall) begin
          pcNext = pcCur;
        end else begin
          pcNext     = pcCur + PC_W'(1);
          fetchValid = 1'b1;
        end
      end
      S_FLUSH: flush = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      rc_q    <= '0;
    end else begin
      case (state_q)
        S_INIT: state_q <= S_RUN;
        S_RUN: begin
          if (redirect) begin
            if (rc_q != 8'hFF) rc_q <= rc_q + 8'd1;
            if (FLUSH_CYCLES > 1) begin
              state_q <= S_FLUSH;
              cnt_q   <= 3'(FLUSH_CYCLES - 1);
            end
          end else if (halt) begin
            state_q <= S_HALT;
          end
        end
        S_FLUSH: begin
          cnt_q <= cnt_q - 3'd1;
          // A zero count can only follow a corrupted load; leave rather than wrap.
          if (cnt_q <= 3'd1) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
          end
        end
        S_HALT: if (resume) state_q <= S_RUN;
        default: state_q <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: default instance plus a FLUSH_CYCLES=1
// instance sharing the same inputs for redirect-count saturation.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst, stall, branchTaken, jump, halt, resume;
  logic [7:0] branchTarget, jumpTarget;
  logic [7:0] pc_reg, pc_force, pcCur;
  logic       use_model;

  logic [7:0] pcNext, redirectCount;
  logic       flush, fetchValid;
  logic [1:0] state;

  logic [7:0] pcNext1, redirectCount1;
  logic       flush1, fetchValid1;
  logic [1:0] state1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // PC register model closing the loop; pcCur can be overridden by the bench.
  always @(posedge clk) pc_reg <= pcNext;
  assign pcCur = use_model ? pc_reg : pc_force;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .pcCur(pcCur), .stall(stall),
    .branchTaken(branchTaken), .branchTarget(branchTarget),
    .jump(jump), .jumpTarget(jumpTarget), .halt(halt), .resume(resume),
    .pcNext(pcNext), .flush(flush), .fetchValid(fetchValid),
    .state(state), .redirectCount(redirectCount)
  );

  pc_sequencer #(.FLUSH_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .pcCur(pcCur), .stall(stall),
    .branchTaken(branchTaken), .branchTarget(branchTarget),
    .jump(jump), .jumpTarget(jumpTarget), .halt(halt), .resume(resume),
    .pcNext(pcNext1), .flush(flush1), .fetchValid(fetchValid1),
    .state(state1), .redirectCount(redirectCount1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] pn, input logic fl,
                         input logic fv, input logic [1:0] st);
    chk({tag, ".pcNext"}, pcNext, pn);
    chk({tag, ".flush"}, {7'd0, flush}, {7'd0, fl});
    chk({tag, ".fetchValid"}, {7'd0, fetchValid}, {7'd0, fv});
    chk({tag, ".state"}, {6'd0, state}, {6'd0, st});
  endtask

  initial begin
    rst = 1'b1; stall = 0; branchTaken = 0; jump = 0; halt = 0; resume = 0;
    branchTarget = 8'h00; jumpTarget = 8'h00; pc_force = 8'h00; use_model = 1'b1;

    // Reset and INIT
    tick(); tick();
    chk_out("reset", 8'h00, 1'b1, 1'b0, 2'd0);
    chk("reset.rc", redirectCount, 8'h00);
    rst = 1'b0;
    jump = 1'b1; jumpTarget = 8'h77;
    #1 chk_out("init", 8'h00, 1'b1, 1'b0, 2'd0);
    tick();
    jump = 1'b0;
    chk("init.rc_ignored", redirectCount, 8'h00);
    #1 chk_out("seq1", 8'h01, 1'b0, 1'b1, 2'd1);
    tick(); chk_out("seq2", 8'h02, 1'b0, 1'b1, 2'd1);
    tick(); chk_out("seq3", 8'h03, 1'b0, 1'b1, 2'd1);

    // Wrap
    use_model = 1'b0; pc_force = 8'hFF;
    #1 chk_out("wrap", 8'h00, 1'b0, 1'b1, 2'd1);
    tick(); chk("wrap.rc", redirectCount, 8'h00);

    // Jump and branch together: jump wins
    pc_force = 8'h10; jump = 1'b1; jumpTarget = 8'h40;
    branchTaken = 1'b1; branchTarget = 8'h20;
    #1 chk_out("jmpbr", 8'h40, 1'b1, 1'b0, 2'd1);
    tick();
    use_model = 1'b1;
    branchTaken = 1'b0; jumpTarget = 8'h99;   // jump held high is ignored in FLUSH
    chk("jmpbr.rc", redirectCount, 8'h01);
    #1 chk_out("flush", 8'h40, 1'b1, 1'b0, 2'd2);
    tick();
    jump = 1'b0;
    #1 chk_out("after_flush", 8'h41, 1'b0, 1'b1, 2'd1);
    chk("flush.rc_ignored", redirectCount, 8'h01);

    // Stall, then branch during stall
    use_model = 1'b0; pc_force = 8'h05; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk_out("stall", 8'h05, 1'b0, 1'b0, 2'd1);
      tick();
    end
    branchTaken = 1'b1; branchTarget = 8'h60;
    #1 chk_out("br_stall", 8'h60, 1'b1, 1'b0, 2'd1);
    tick();
    branchTaken = 1'b0; stall = 1'b0;
    chk("br_stall.rc", redirectCount, 8'h02);
    chk("br_stall.state", {6'd0, state}, 8'd2);
    tick();
    chk("br_stall.run", {6'd0, state}, 8'd1);

    // Halt / resume
    pc_force = 8'h30; halt = 1'b1;
    #1 chk_out("halt", 8'h30, 1'b0, 1'b0, 2'd1);
    tick();
    halt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      jump = (i >= 4); jumpTarget = 8'h50; stall = (i == 2);
      #1 chk_out("halted", 8'h30, 1'b0, 1'b0, 2'd3);
      tick();
    end
    jump = 1'b0; stall = 1'b0; resume = 1'b1;
    #1 chk_out("resume", 8'h30, 1'b0, 1'b0, 2'd3);
    tick();
    resume = 1'b0;
    #1 chk_out("resumed", 8'h31, 1'b0, 1'b1, 2'd1);
    chk("halt.rc", redirectCount, 8'h02);

    // Saturation: fresh reset, then 256 back-to-back jumps
    rst = 1'b1; tick(); tick();
    rst = 1'b0; tick();
    jump = 1'b1; jumpTarget = 8'h80;
    for (int i = 1; i <= 256; i++) begin
      tick();
      if (i == 1)   chk("fc1.state_run", {6'd0, state1}, 8'd1);
      if (i == 254) chk("sat.254", redirectCount1, 8'hFE);
      if (i == 255) chk("sat.255", redirectCount1, 8'hFF);
    end
    chk("sat.256", redirectCount1, 8'hFF);
    chk("fc1.flush", {7'd0, flush1}, 8'd1);
    chk("alt.rc", redirectCount, 8'h80);

    // Reset mid-FLUSH
    tick();
    jump = 1'b0;
    chk("pre_rst.state", {6'd0, state}, 8'd2);
    chk("pre_rst.rc", redirectCount, 8'h81);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1 chk_out("rst_flush", 8'h00, 1'b1, 1'b0, 2'd0);
    chk("rst_flush.rc", redirectCount, 8'h00);
    chk("rst_flush.rc1", redirectCount1, 8'h00);

    // Reset mid-HALT
    tick();
    halt = 1'b1; tick(); halt = 1'b0;
    chk("pre_rst_halt", {6'd0, state}, 8'd3);
    rst = 1'b1; tick(); rst = 1'b0;
    #1 chk_out("rst_halt", 8'h00, 1'b1, 1'b0, 2'd0);
    tick();
    chk("rst_halt.run", {6'd0, state}, 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
